q_argmax_seq: RTL and testbench

- Sequential, parametrised successor to the combinational 9-input Q-value maximum used by the tic-tac-toe agent.
- Scans N packed Q-values one per clock and returns both the maximum value and its action index.
- Honours a legal-action mask, so occupied board cells are never selected.
- Sits between the Q-table read port and the action-selection / move-commit logic. It uses a start/busy/done handshake, so one comparator serves any board size.

---
 rtl/q_argmax_seq.sv | 123 ++++++++++++
 tb/tb_q_argmax_seq.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_argmax_seq.sv
// q_argmax_seq: sequential masked argmax over N_ACTIONS packed Q-values.
// Scans one latched element per clock and reports the largest eligible value
// and its lowest-index position, with a start/busy/done handshake.
// Optional build macro: Q_ARGMAX_SIGNED_EN (signed two's-complement compare).
//
// State    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; outputs hold the last completed result
// ST_SCAN  | examining element cnt of the latched vector
// ST_DONE  | one-cycle completion pulse; result already on the outputs
module q_argmax_seq #(
  parameter int N_ACTIONS = 9,
  parameter int Q_WIDTH   = 8,
  parameter int IDX_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [N_ACTIONS*Q_WIDTH-1:0]   q_in,
  input  logic [N_ACTIONS-1:0]           mask_in,
  output logic                           busy,
  output logic                           done,
  output logic                           found,
  output logic [Q_WIDTH-1:0]             max_q,
  output logic [IDX_WIDTH-1:0]           max_idx
);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_ACTIONS - 1);

  state_t                         state;
  logic [N_ACTIONS*Q_WIDTH-1:0]   q_r;
  logic [N_ACTIONS-1:0]           mask_r;
  logic [IDX_WIDTH-1:0]           cnt;
  logic                           have_best;
  logic [Q_WIDTH-1:0]             best_q;
  logic [IDX_WIDTH-1:0]           best_idx;

  logic [Q_WIDTH-1:0]             cur_q;
  logic                           cur_m;
  logic                           cur_gt;
  logic                           upd;
  logic [Q_WIDTH-1:0]             nxt_q;
  logic [IDX_WIDTH-1:0]           nxt_idx;
  logic                           nxt_have;

  // Compare the current element against the running best; strict greater-than
  // keeps the earliest index on ties.
  always_comb begin
    cur_q = q_r[int'(cnt)*Q_WIDTH +: Q_WIDTH];
    cur_m = mask_r[cnt];
`ifdef Q_ARGMAX_SIGNED_EN
    cur_gt = $signed(cur_q) > $signed(best_q);
`else
    cur_gt = cur_q > best_q;
`endif
    upd      = cur_m && (!have_best || cur_gt);
    nxt_q    = upd ? cur_q : best_q;
    nxt_idx  = upd ? cnt : best_idx;
    nxt_have = have_best | upd;
  end

  // Sequencer: latch on start, scan one element per edge, publish on DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      q_r       <= '0;
      mask_r    <= '0;
      cnt       <= '0;
      have_best <= 1'b0;
      best_q    <= '0;
      best_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      max_q     <= '0;
      max_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            q_r       <= q_in;
            mask_r    <= mask_in;
            cnt       <= '0;
            have_best <= 1'b0;
            best_q    <= '0;
            best_idx  <= '0;
            busy      <= 1'b1;
            state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          best_q    <= nxt_q;
          best_idx  <= nxt_idx;
          have_best <= nxt_have;
          if (cnt == LAST_IDX) begin
            // Outputs include the final element's contribution on this edge.
            found   <= nxt_have;
            max_q   <= nxt_have ? nxt_q : '0;
            max_idx <= nxt_have ? nxt_idx : '0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_q_argmax_seq.sv
// Testbench for q_argmax_seq: scoreboarded results plus latency, hold,
// busy-start, abort and reset checks. Honours Q_ARGMAX_SIGNED_EN.
module tb_q_argmax_seq;
  localparam int N  = 9;
  localparam int QW = 8;
  localparam int IW = 4;

`ifdef Q_ARGMAX_SIGNED_EN
  localparam logic [QW-1:0] T1_Q   = 8'd9;
  localparam logic [IW-1:0] T1_IDX = 4'd8;
`else
  localparam logic [QW-1:0] T1_Q   = 8'd212;
  localparam logic [IW-1:0] T1_IDX = 4'd1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [N*QW-1:0]   q_in;
  logic [N-1:0]      mask_in;
  logic              busy;
  logic              done;
  logic              found;
  logic [QW-1:0]     max_q;
  logic [IW-1:0]     max_idx;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic          found;
    logic [QW-1:0] q;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  q_argmax_seq #(.N_ACTIONS(N), .Q_WIDTH(QW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .q_in(q_in), .mask_in(mask_in),
    .busy(busy), .done(done), .found(found), .max_q(max_q), .max_idx(max_idx)
  );

  function automatic logic gt(input logic [QW-1:0] a, input logic [QW-1:0] b);
`ifdef Q_ARGMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Reference: find the max value (scanning downward), then its lowest index.
  function automatic exp_t model(input logic [N*QW-1:0] q, input logic [N-1:0] m);
    exp_t r;
    logic [QW-1:0] best;
    logic any;
    r = '0;
    best = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i] && (!any || gt(q[i*QW +: QW], best))) begin
        best = q[i*QW +: QW];
        any = 1'b1;
      end
    end
    if (any) begin
      r.found = 1'b1;
      r.q = best;
      for (int i = 0; i < N; i++) begin
        if (m[i] && q[i*QW +: QW] == best) begin
          r.idx = IW'(i);
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [N*QW-1:0] pk(input logic [QW-1:0] e [N]);
    logic [N*QW-1:0] r;
    for (int i = 0; i < N; i++) r[i*QW +: QW] = e[i];
    return r;
  endfunction

  // Scoreboard: every done pulse pops and compares one expected result.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: got done with empty queue, required no done");
      end else begin
        e = sb.pop_front();
        if ({found, max_q, max_idx} !== e) begin
          errors++;
          $display("FAIL sb_result: got found=%0b q=%0d idx=%0d, required found=%0b q=%0d idx=%0d",
                   found, max_q, max_idx, e.found, e.q, e.idx);
        end
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL sb_busy_with_done: got %0b required 1", busy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [N*QW-1:0] q, input logic [N-1:0] m);
    q_in = q;
    mask_in = m;
    start = 1'b1;
    sb.push_back(model(q, m));
    tick();
    start = 1'b0;
    q_in = ~q;
    mask_in = ~m;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done) begin
        lat = c;
        return;
      end
    end
  endtask

  task automatic test_reset();
    int c;
    rst = 1'b1;
    start = 1'b0;
    q_in = '1;
    mask_in = '1;
    tick();
    tick();
    rst = 1'b0;
    c = {31'd0, busy} + {31'd0, done} + {31'd0, found};
    checks++;
    if (c != 0) begin
      errors++;
      $display("FAIL reset_flags: got busy=%0b done=%0b found=%0b required 0 0 0", busy, done, found);
    end
    checks++;
    if (max_q !== '0 || max_idx !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got q=%0d idx=%0d required 0 0", max_q, max_idx);
    end
  endtask

  task automatic test_basic();
    int lat;
    launch(pk('{8'd1, 8'd212, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}), 9'h1FF);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: got busy=%0b done=%0b required 1 0", busy, done);
    end
    wait_done(lat);
    checks++;
    if (lat != N) begin
      errors++;
      $display("FAIL basic_latency: got %0d required %0d", lat, N);
    end
    checks++;
    if (max_q !== T1_Q || max_idx !== T1_IDX || found !== 1'b1) begin
      errors++;
      $display("FAIL basic_result: got q=%0d idx=%0d found=%0b required %0d %0d 1",
               max_q, max_idx, found, T1_Q, T1_IDX);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: got busy=%0b done=%0b required 0 0", busy, done);
    end
  endtask

  task automatic test_mask();
    int lat;
    logic [N*QW-1:0] v;
    v = pk('{8'd1, 8'd22, 8'd3, 8'd45, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9});
    launch(v, 9'h1FF);
    wait_done(lat);
    checks++;
    if (max_q !== 8'd45 || max_idx !== 4'd3) begin
      errors++;
      $display("FAIL mask_full: got q=%0d idx=%0d required 45 3", max_q, max_idx);
    end
    tick();
    launch(v, 9'h1F7);
    wait_done(lat);
    checks++;
    if (max_q !== 8'd22 || max_idx !== 4'd1) begin
      errors++;
      $display("FAIL mask_bit3: got q=%0d idx=%0d required 22 1", max_q, max_idx);
    end
    tick();
  endtask

  task automatic test_ties();
    int lat;
    logic [N*QW-1:0] v;
    v = pk('{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7});
    launch(v, 9'h1FF);
    wait_done(lat);
    checks++;
    if (max_q !== 8'd7 || max_idx !== 4'd0) begin
      errors++;
      $display("FAIL tie_low: got q=%0d idx=%0d required 7 0", max_q, max_idx);
    end
    tick();
    launch(v, 9'h1F0);
    wait_done(lat);
    checks++;
    if (max_idx !== 4'd4) begin
      errors++;
      $display("FAIL tie_masked: got idx=%0d required 4", max_idx);
    end
    tick();
  endtask

  task automatic test_empty();
    int lat;
    launch(pk('{8'd90, 8'd91, 8'd92, 8'd93, 8'd94, 8'd95, 8'd96, 8'd97, 8'd98}), 9'h000);
    wait_done(lat);
    checks++;
    if (lat != N) begin
      errors++;
      $display("FAIL empty_latency: got %0d required %0d", lat, N);
    end
    checks++;
    if (found !== 1'b0 || max_q !== '0 || max_idx !== '0) begin
      errors++;
      $display("FAIL empty_result: got found=%0b q=%0d idx=%0d required 0 0 0", found, max_q, max_idx);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    launch(pk('{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd5}), 9'h1FF);
    wait_done(lat);
    tick();
    launch(pk('{8'd99, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}), 9'h1FF);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%0b required 1", busy);
    end
    repeat (4) tick();
    checks++;
    if (max_q !== 8'd80 || max_idx !== 4'd7) begin
      errors++;
      $display("FAIL b2b_hold: got q=%0d idx=%0d required 80 7", max_q, max_idx);
    end
    wait_done(lat);
    checks++;
    if (lat != N - 4) begin
      errors++;
      $display("FAIL b2b_latency: got %0d required %0d", lat, N - 4);
    end
    tick();
    repeat (3) tick();
    checks++;
    if (max_q !== 8'd99 || max_idx !== 4'd0) begin
      errors++;
      $display("FAIL idle_hold: got q=%0d idx=%0d required 99 0", max_q, max_idx);
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    int d0;
    d0 = done_cnt;
    launch(pk('{8'd3, 8'd33, 8'd13, 8'd23, 8'd43, 8'd8, 8'd2, 8'd1, 8'd0}), 9'h1FF);
    tick();
    tick();
    q_in = pk('{8'd250, 8'd250, 8'd250, 8'd250, 8'd250, 8'd250, 8'd250, 8'd250, 8'd250});
    mask_in = 9'h1FF;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat);
    checks++;
    if (lat != N - 3) begin
      errors++;
      $display("FAIL busy_start_latency: got %0d required %0d", lat, N - 3);
    end
    checks++;
    if (max_q !== 8'd43 || max_idx !== 4'd4) begin
      errors++;
      $display("FAIL busy_start_result: got q=%0d idx=%0d required 43 4", max_q, max_idx);
    end
    repeat (15) tick();
    checks++;
    if (done_cnt - d0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_ignored: got %0d dones busy=%0b required 1 dones busy=0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_abort();
    int d0;
    launch(pk('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd200, 8'd9}), 9'h1FF);
    repeat (3) tick();
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || found !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags: got busy=%0b done=%0b found=%0b required 0 0 0", busy, done, found);
    end
    checks++;
    if (max_q !== 8'd0 || max_idx !== 4'd0) begin
      errors++;
      $display("FAIL abort_outputs: got q=%0d idx=%0d required 0 0", max_q, max_idx);
    end
    repeat (15) tick();
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d dones required 0", done_cnt - d0);
    end
    q_in = pk('{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9});
    mask_in = 9'h1FF;
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_beats_start: got busy=%0b required 0", busy);
    end
    tick();
  endtask

  task automatic test_signed();
    int lat;
    launch(pk('{8'h80, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB, 8'hFB}), 9'h1FF);
    wait_done(lat);
    checks++;
    if (max_q !== 8'hFB || max_idx !== 4'd1 || found !== 1'b1) begin
      errors++;
      $display("FAIL signed_vec: got q=%0h idx=%0d found=%0b required fb 1 1", max_q, max_idx, found);
    end
    tick();
  endtask

  task automatic test_random();
    int lat;
    logic [N*QW-1:0] v;
    logic [N-1:0] m;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < N; i++) v[i*QW +: QW] = QW'($urandom_range(0, 15) * 17);
      m = N'($urandom);
      launch(v, m);
      wait_done(lat);
      checks++;
      if (lat != N) begin
        errors++;
        $display("FAIL random_latency: got %0d required %0d", lat, N);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    q_in = '0;
    mask_in = '0;
    test_reset();
    test_basic();
    test_mask();
    test_ties();
    test_empty();
    test_back_to_back();
    test_start_while_busy();
    test_abort();
    test_signed();
    test_random();
    repeat (3) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending results required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
